// File: rtl/trace_noc_pkg.sv
// Shared types and constants for the trace-to-NoC packetizer.
package trace_noc_pkg;

    localparam logic [1:0] FLIT_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_LAST    = 2'b10;

    localparam logic [2:0] TRACE_CLASS  = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PC,
        INSN,
        DATA
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
    } trace_record_t;

    function automatic logic [31:0] header_data(
        input logic [4:0]    dest,
        input logic [4:0]    tile,
        input trace_record_t rec,
        input logic [7:0]    drops
    );
        return {dest, TRACE_CLASS, tile, rec.wben, rec.wbreg, 5'b0, drops};
    endfunction

endpackage

// File: rtl/trace_noc_packetizer_fifo.sv
// Synchronous FIFO of trace records; exposes the head and the entry behind it.
module trace_record_fifo
    import trace_noc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  trace_record_t wr_data_i,
    output logic          full_o,
    output logic          empty_o,
    output logic          two_plus_o,
    output trace_record_t head_o,
    output trace_record_t second_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    trace_record_t mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_en;
    logic          pop_en;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign two_plus_o = (count_q > CW'(1));

    // A pop frees the slot the write lands in, so a full FIFO may still accept.
    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & (~full_o | pop_en);

    assign head_o   = mem_q[rd_ptr_q];
    assign second_o = mem_q[rd_ptr_q + AW'(1)];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_en) - CW'(pop_en);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/trace_noc_packetizer.sv
// Captures retired-instruction trace records and serializes them as NoC packets,
// counting records dropped under back-pressure.
module trace_noc_packetizer
    import trace_noc_pkg::*;
#(
    parameter int unsigned NOC_FLIT_DATA_WIDTH = 32,
    parameter int unsigned NOC_FLIT_TYPE_WIDTH = 2,
    parameter int unsigned FIFO_DEPTH          = 4,
    parameter logic [4:0]  TILE_ID             = 5'd0,
    parameter logic [4:0]  DEST_ID             = 5'd0
) (
    input  logic                                           clk,
    input  logic                                           rst_sys_n,
    input  logic                                           trace_enable,
    input  logic [31:0]                                    trace_pc,
    input  logic [31:0]                                    trace_insn,
    input  logic                                           trace_wben,
    input  logic [4:0]                                     trace_wbreg,
    input  logic [31:0]                                    trace_wbdata,
    output logic [NOC_FLIT_TYPE_WIDTH+NOC_FLIT_DATA_WIDTH-1:0] noc_out_flit,
    output logic                                           noc_out_valid,
    input  logic                                           noc_out_ready,
    output logic                                           busy,
    output logic [7:0]                                     drop_count
);

    localparam int unsigned FW = NOC_FLIT_TYPE_WIDTH + NOC_FLIT_DATA_WIDTH;

    state_e        state_q, state_d;
    logic [FW-1:0] flit_q, flit_d;
    logic          valid_q, valid_d;
    logic [7:0]    drop_q, drop_d;
    logic [7:0]    drop_base;

    trace_record_t in_rec;
    trace_record_t hdr_rec;
    trace_record_t fifo_head;
    trace_record_t fifo_second;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_two_plus;

    logic          hs;
    logic          last_hs;
    logic          push_ok;
    logic          drop;
    logic          hdr_clear;
    logic          more_after_pop;
    logic [FW-1:0] next_hdr_flit;

    assign in_rec = '{pc:     trace_pc,
                      insn:   trace_insn,
                      wben:   trace_wben,
                      wbreg:  trace_wbreg,
                      wbdata: trace_wbdata};

    assign hs      = valid_q & noc_out_ready;
    assign last_hs = hs & (((state_q == INSN) & ~fifo_head.wben) | (state_q == DATA));
    assign push_ok = trace_enable & (~fifo_full | last_hs);
    assign drop    = trace_enable & ~push_ok;

    // The head is only popped on the LAST handshake, so the next packet's record
    // is the second entry, or the record being captured this very cycle.
    assign more_after_pop = fifo_two_plus | push_ok;

    trace_record_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (rst_sys_n),
        .push_i     (push_ok),
        .pop_i      (last_hs),
        .wr_data_i  (in_rec),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .two_plus_o (fifo_two_plus),
        .head_o     (fifo_head),
        .second_o   (fifo_second)
    );

    always_comb begin
        hdr_rec = in_rec;
        if ((state_q == IDLE) && !fifo_empty) begin
            hdr_rec = fifo_head;
        end else if ((state_q != IDLE) && fifo_two_plus) begin
            hdr_rec = fifo_second;
        end
        next_hdr_flit = {FLIT_HEADER, header_data(DEST_ID, TILE_ID, hdr_rec, drop_q)};
    end

    always_comb begin
        state_d = state_q;
        flit_d  = flit_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty || push_ok) begin
                    state_d = HDR;
                    flit_d  = next_hdr_flit;
                    valid_d = 1'b1;
                end
            end
            HDR: begin
                if (hs) begin
                    state_d = PC;
                    flit_d  = {FLIT_PAYLOAD, fifo_head.pc};
                end
            end
            PC: begin
                if (hs) begin
                    state_d = INSN;
                    flit_d  = {(fifo_head.wben ? FLIT_PAYLOAD : FLIT_LAST), fifo_head.insn};
                end
            end
            INSN: begin
                if (hs && fifo_head.wben) begin
                    state_d = DATA;
                    flit_d  = {FLIT_LAST, fifo_head.wbdata};
                end
            end
            DATA: begin
            end
            default: begin
                state_d = IDLE;
                flit_d  = '0;
                valid_d = 1'b0;
            end
        endcase
        if (last_hs) begin
            if (more_after_pop) begin
                state_d = HDR;
                flit_d  = next_hdr_flit;
            end else begin
                state_d = IDLE;
                flit_d  = '0;
                valid_d = 1'b0;
            end
        end
    end

    // Clearing subtracts the value the header carried, so drops that land while
    // the header is stalled survive into the next count.
    assign hdr_clear = hs & (state_q == HDR);
    assign drop_base = hdr_clear ? (drop_q - flit_q[7:0]) : drop_q;
    assign drop_d    = (drop && (drop_base != 8'hFF)) ? (drop_base + 8'd1) : drop_base;

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q <= IDLE;
            flit_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign noc_out_flit  = flit_q;
    assign noc_out_valid = valid_q;
    assign drop_count    = drop_q;
    assign busy          = ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_trace_noc_packetizer.sv
// Self-checking bench for trace_noc_packetizer against a queue-based packet model.
module tb_trace_noc_packetizer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        trace_enable = 1'b0;
    logic [31:0] trace_pc = '0;
    logic [31:0] trace_insn = '0;
    logic        trace_wben = 1'b0;
    logic [4:0]  trace_wbreg = '0;
    logic [31:0] trace_wbdata = '0;
    logic [33:0] noc_out_flit;
    logic        noc_out_valid;
    logic        noc_out_ready = 1'b0;
    logic        busy;
    logic [7:0]  drop_count;

    trace_noc_packetizer #(
        .NOC_FLIT_DATA_WIDTH (32),
        .NOC_FLIT_TYPE_WIDTH (2),
        .FIFO_DEPTH          (DEPTH),
        .TILE_ID             (5'd0),
        .DEST_ID             (5'd0)
    ) dut (
        .clk           (clk),
        .rst_sys_n     (rst_sys_n),
        .trace_enable  (trace_enable),
        .trace_pc      (trace_pc),
        .trace_insn    (trace_insn),
        .trace_wben    (trace_wben),
        .trace_wbreg   (trace_wbreg),
        .trace_wbdata  (trace_wbdata),
        .noc_out_flit  (noc_out_flit),
        .noc_out_valid (noc_out_valid),
        .noc_out_ready (noc_out_ready),
        .busy          (busy),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: records accepted but not yet fully sent, flits still owed, drop counter.
    rec_t        mq[$];
    logic [33:0] exp_q[$];
    int          mdrop = 0;
    bit          active = 1'b0;

    bit          t_hs, t_unexp, t_valid;
    logic [33:0] t_flit, t_got, t_exp;
    logic [33:0] d_got, d_exp, d_last;
    int          hdr_seen[$];
    rec_t        idle_rec = '{default: '0};

    function automatic logic [33:0] hdr_flit(input rec_t r, input int drops);
        logic [31:0] d;
        d = (32'd6 << 24) | (32'(r.wben) << 18) | (32'(r.wbreg) << 13) | 32'(drops & 255);
        return {2'b01, d};
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        r.pc     = $urandom;
        r.insn   = $urandom;
        r.wben   = 1'($urandom_range(0, 1));
        r.wbreg  = 5'($urandom_range(0, 31));
        r.wbdata = $urandom;
        return r;
    endfunction

    task automatic start_packet(input rec_t r, input int drops);
        exp_q.push_back(hdr_flit(r, drops));
        exp_q.push_back({2'b00, r.pc});
        if (r.wben) begin
            exp_q.push_back({2'b00, r.insn});
            exp_q.push_back({2'b10, r.wbdata});
        end else begin
            exp_q.push_back({2'b10, r.insn});
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        mdrop  = 0;
        active = 1'b0;
    endtask

    // One clock: drive at negedge, observe, advance the model, wait for next negedge.
    task automatic tick(input bit en, input rec_t r, input bit rdy);
        bit          pop, clr, push_ok, drop;
        int          pre, base;
        logic [33:0] ef;
        trace_enable  = en;
        trace_pc      = r.pc;
        trace_insn    = r.insn;
        trace_wben    = r.wben;
        trace_wbreg   = r.wbreg;
        trace_wbdata  = r.wbdata;
        noc_out_ready = rdy;
        #1;
        t_valid = noc_out_valid;
        t_flit  = noc_out_flit;
        t_hs    = noc_out_valid && rdy;
        t_unexp = 1'b0;
        t_got   = noc_out_flit;
        t_exp   = 'x;
        pop = 1'b0;
        clr = 1'b0;
        ef  = '0;
        if (t_hs) begin
            if (exp_q.size() == 0) begin
                t_unexp = 1'b1;
            end else begin
                ef    = exp_q.pop_front();
                t_exp = ef;
                pop   = (ef[33:32] == 2'b10);
                clr   = (ef[33:32] == 2'b01);
            end
        end
        push_ok = en && ((mq.size() < DEPTH) || pop);
        drop    = en && !push_ok;
        pre     = mdrop;
        base    = clr ? (mdrop - int'(ef[7:0])) : mdrop;
        if (drop && base < 255) base++;
        mdrop = base;
        if (pop) void'(mq.pop_front());
        if (push_ok) mq.push_back(r);
        if ((pop || !active) && mq.size() > 0) begin
            start_packet(mq[0], pre);
            active = 1'b1;
        end else if (pop) begin
            active = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles, input bit rand_rdy,
                         output int nflits, output int bad, output int gaps);
        int cyc = 0;
        nflits = 0;
        bad    = 0;
        gaps   = 0;
        hdr_seen.delete();
        while (exp_q.size() > 0 && cyc < max_cycles) begin
            tick(1'b0, idle_rec, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            cyc++;
            if (!t_valid) gaps++;
            if (t_hs) begin
                nflits++;
                d_last = t_got;
                if (t_got[33:32] == 2'b01) hdr_seen.push_back(int'(t_got[7:0]));
                if (t_unexp || t_got !== t_exp) begin
                    if (bad == 0) begin
                        d_got = t_got;
                        d_exp = t_exp;
                    end
                    bad++;
                end
            end
        end
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if (noc_out_valid !== 1'b0 || noc_out_flit !== 34'h0 || busy !== 1'b0 || drop_count !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b flit=%h busy=%b drops=%0d, required 0/0/0/0",
                     noc_out_valid, noc_out_flit, busy, drop_count);
        end
        @(negedge clk);
        rst_sys_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        rec_t r;
        int   nf, bad, gaps;
        r = '{pc: 32'h100, insn: 32'h1500_0000, wben: 1'b0, wbreg: 5'd0, wbdata: 32'h0};
        tick(1'b1, r, 1'b1);
        n_tests++;
        if (noc_out_valid !== 1'b1 || noc_out_flit !== 34'h1_0600_0000) begin
            n_fail++;
            $display("FAIL single_hdr_latency: valid=%b flit=%h, required 1 / 106000000",
                     noc_out_valid, noc_out_flit);
        end
        drain(20, 1'b0, nf, bad, gaps);
        n_tests++;
        if (nf != 3 || bad != 0 || d_last !== 34'h2_1500_0000) begin
            n_fail++;
            $display("FAIL single_flits: count=%0d bad=%0d got=%h exp=%h last=%h, required 3 flits ending 215000000",
                     nf, bad, d_got, d_exp, d_last);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_falls: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_wben();
        rec_t r;
        int   nf, bad, gaps;
        r = rand_rec();
        r.wben   = 1'b1;
        r.wbreg  = 5'd3;
        r.wbdata = 32'hDEAD_BEEF;
        tick(1'b1, r, 1'b1);
        n_tests++;
        if (noc_out_flit !== 34'h1_0604_6000) begin
            n_fail++;
            $display("FAIL wben_header: flit=%h, required 106046000", noc_out_flit);
        end
        drain(20, 1'b0, nf, bad, gaps);
        n_tests++;
        if (nf != 4 || bad != 0 || d_last !== 34'h2_DEAD_BEEF) begin
            n_fail++;
            $display("FAIL wben_flits: count=%0d bad=%0d got=%h exp=%h last=%h, required 4 flits ending 2deadbeef",
                     nf, bad, d_got, d_exp, d_last);
        end
    endtask

    task automatic test_backpressure();
        rec_t r;
        int   nf, bad, gaps;
        for (int i = 0; i < 6; i++) begin
            r = rand_rec();
            r.wben = 1'b0;
            tick(1'b1, r, 1'b0);
        end
        n_tests++;
        if (drop_count !== 8'd2) begin
            n_fail++;
            $display("FAIL bp_drop_count: drops=%0d, required 2", drop_count);
        end
        drain(12, 1'b0, nf, bad, gaps);
        n_tests++;
        if (nf != 12 || gaps != 0 || bad != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_packets: flits=%0d gaps=%0d bad=%0d got=%h exp=%h left=%0d, required 12/0/0",
                     nf, gaps, bad, d_got, d_exp, exp_q.size());
        end
        n_tests++;
        if (hdr_seen.size() != 4 || hdr_seen[0] != 0 || hdr_seen[1] != 2 || hdr_seen[2] != 0) begin
            n_fail++;
            $display("FAIL bp_header_drops: headers=%0d first=%0d second=%0d, required 4 headers carrying 0,2,0",
                     hdr_seen.size(), (hdr_seen.size() > 0) ? hdr_seen[0] : -1,
                     (hdr_seen.size() > 1) ? hdr_seen[1] : -1);
        end
        n_tests++;
        if (drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL bp_drop_cleared: drops=%0d, required 0", drop_count);
        end
    endtask

    task automatic test_same_cycle_drop();
        int nf, bad, gaps;
        for (int i = 0; i < 4; i++) tick(1'b1, rand_rec(), 1'b0);
        tick(1'b1, rand_rec(), 1'b1);
        n_tests++;
        if (drop_count !== 8'd1) begin
            n_fail++;
            $display("FAIL same_cycle_drop: drops=%0d, required 1", drop_count);
        end
        drain(40, 1'b0, nf, bad, gaps);
        n_tests++;
        if (bad != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL same_cycle_drain: bad=%0d got=%h exp=%h left=%0d", bad, d_got, d_exp, exp_q.size());
        end
    endtask

    task automatic test_random();
        bit          pv, pr;
        logic [33:0] pf;
        int          nf, bad, gaps;
        pv = 1'b0;
        pr = 1'b0;
        pf = '0;
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 1)), rand_rec(), ($urandom_range(0, 2) != 0));
            if (pv && !pr) begin
                n_tests++;
                if (t_valid !== 1'b1 || t_flit !== pf) begin
                    n_fail++;
                    $display("FAIL rand_stall_hold: cycle %0d valid=%b flit=%h, required 1 / %h", i, t_valid, t_flit, pf);
                end
            end
            if (t_hs) begin
                n_tests++;
                if (t_unexp || t_got !== t_exp) begin
                    n_fail++;
                    $display("FAIL rand_flit: cycle %0d got=%h exp=%h", i, t_got, t_exp);
                end
            end
            n_tests++;
            if (drop_count !== 8'(mdrop)) begin
                n_fail++;
                $display("FAIL rand_drop_count: cycle %0d drops=%0d, required %0d", i, drop_count, mdrop);
            end
            pv = t_valid;
            pr = noc_out_ready;
            pf = t_flit;
        end
        drain(200, 1'b1, nf, bad, gaps);
        n_tests++;
        if (bad != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: bad=%0d got=%h exp=%h left=%0d", bad, d_got, d_exp, exp_q.size());
        end
    endtask

    task automatic test_saturation_reset();
        rec_t r;
        int   nf, bad, gaps;
        for (int i = 0; i < 304; i++) tick(1'b1, rand_rec(), 1'b0);
        n_tests++;
        if (drop_count !== 8'd255 || noc_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_drop_count: drops=%0d valid=%b, required 255 / 1", drop_count, noc_out_valid);
        end
        trace_enable = 1'b0;
        #2;
        rst_sys_n = 1'b0;
        #1;
        n_tests++;
        if (noc_out_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 8'd0 || noc_out_flit !== 34'h0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b busy=%b drops=%0d flit=%h, required 0/0/0/0",
                     noc_out_valid, busy, drop_count, noc_out_flit);
        end
        model_reset();
        @(negedge clk);
        rst_sys_n = 1'b1;
        r = rand_rec();
        tick(1'b1, r, 1'b1);
        n_tests++;
        if (noc_out_valid !== 1'b1 || noc_out_flit !== hdr_flit(r, 0)) begin
            n_fail++;
            $display("FAIL post_reset_header: valid=%b flit=%h, required 1 / %h", noc_out_valid, noc_out_flit, hdr_flit(r, 0));
        end
        drain(20, 1'b0, nf, bad, gaps);
        n_tests++;
        if (bad != 0 || nf != (r.wben ? 4 : 3) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_packet: flits=%0d bad=%0d got=%h exp=%h busy=%b", nf, bad, d_got, d_exp, busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_wben();
        test_backpressure();
        test_same_cycle_drop();
        test_random();
        test_saturation_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
